apu_reg_encoder: RTL and testbench

Serial transmitter for the APU register link: accepts 3-bit address / 8-bit data register writes on a valid/ready handshake and shifts each one out as a framed `sck`/`sdi` bit stream toward the APU register decoder. It sits on the host/controller side of the link, is the single driver of `sck` and `sdi`, and runs entirely in the system clock domain.

---
 rtl/apu_reg_encoder.sv | 140 ++++++++++++++
 tb/tb_apu_reg_encoder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apu_reg_encoder.sv
// APU register link serial transmitter: framed sck/sdi writes.
// Optional even-parity 13th bit enabled by APU_ENC_PARITY_EN.
module apu_reg_encoder #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   output logic       sck,
   output logic       sdi,
   output logic       busy
);

`ifdef APU_ENC_PARITY_EN
   localparam int unsigned NBITS = 13;
`else
   localparam int unsigned NBITS = 12;
`endif
   localparam int unsigned PW = $clog2(CLK_DIV + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
   localparam logic [3:0] BIT_LAST = 4'(NBITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    phase_q, phase_d;
   logic [3:0]       bit_q, bit_d;
   logic [NBITS-1:0] shreg_q, shreg_d;
   logic             sck_q, sck_d;
   logic             sdi_q, sdi_d;
   logic             gap_half_q, gap_half_d;
   logic [NBITS-1:0] frame;
   logic             phase_last;

`ifdef APU_ENC_PARITY_EN
   assign frame = {1'b1, wr_addr, wr_data, ^{wr_addr, wr_data}};
`else
   assign frame = {1'b1, wr_addr, wr_data};
`endif

   assign phase_last = (phase_q == PH_LAST);
   assign wr_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign sck        = sck_q;
   assign sdi        = sdi_q;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      sck_d      = sck_q;
      sdi_d      = sdi_q;
      gap_half_d = gap_half_q;
      unique case (state_q)
         IDLE: begin
            sck_d = 1'b0;
            sdi_d = 1'b0;
            if (wr_valid) begin
               state_d = SHIFT;
               shreg_d = frame;
               sdi_d   = frame[NBITS-1];
               phase_d = '0;
               bit_d   = '0;
            end
         end
         SHIFT: begin
            if (!phase_last) begin
               phase_d = phase_q + PW'(1);
            end else begin
               phase_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  sck_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d    = GAP;
                     sdi_d      = 1'b0;
                     bit_d      = '0;
                     shreg_d    = '0;
                     gap_half_d = 1'b0;
                  end else begin
                     // current bit sits in the MSB; next one is below it
                     bit_d   = bit_q + 4'd1;
                     sdi_d   = shreg_q[NBITS-2];
                     shreg_d = {shreg_q[NBITS-2:0], 1'b0};
                  end
               end
            end
         end
         GAP: begin
            sck_d = 1'b0;
            sdi_d = 1'b0;
            if (!phase_last) begin
               phase_d = phase_q + PW'(1);
            end else begin
               phase_d    = '0;
               gap_half_d = 1'b1;
               if (gap_half_q) begin
                  state_d    = IDLE;
                  gap_half_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            sck_d   = 1'b0;
            sdi_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         sck_q      <= 1'b0;
         sdi_q      <= 1'b0;
         gap_half_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         sck_q      <= sck_d;
         sdi_q      <= sdi_d;
         gap_half_q <= gap_half_d;
      end
   end

endmodule

// File: tb/tb_apu_reg_encoder.sv
// Bench for apu_reg_encoder: frame capture vs. a word-level model.
// Build with APU_ENC_PARITY_EN to exercise the 13-bit CLK_DIV=1 config.
module tb_apu_reg_encoder;

`ifdef APU_ENC_PARITY_EN
   localparam int CD = 1;
   localparam int NB = 13;
`else
   localparam int CD = 2;
   localparam int NB = 12;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [2:0] wr_addr = '0;
   logic [7:0] wr_data = '0;
   logic       sck;
   logic       sdi;
   logic       busy;

   int checks = 0;
   int failures = 0;

   int c1_ok, pre_ready, n_edges, first_edge, ready_cyc;
   int edge_bad, gap_bad, busy_bad, unstable;
   int got_word;

   apu_reg_encoder #(.CLK_DIV(CD)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .sck(sck), .sdi(sdi), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int model_word(input int a, input int d);
      int w;
      w = (1 << 11) | ((a & 7) << 8) | (d & 255);
      if (NB == 13) w = (w << 1) | ($countones((a & 7) * 256 + (d & 255)) % 2);
      return w;
   endfunction

   function automatic int model_ready_cyc();
      return 1 + (NB + 1) * 2 * CD;
   endfunction

   // Called just after a negedge with wr_ready sampled; captures one frame.
   task automatic run_frame(input int a, input int d, input bit hold,
                            input int na, input int nd, input bit chg);
      int c;
      logic ps, pd;
      pre_ready = wr_ready;
      wr_valid = 1'b1;
      wr_addr = a[2:0];
      wr_data = d[7:0];
      @(posedge clk);
      #1;
      if (hold) begin
         wr_addr = na[2:0];
         wr_data = nd[7:0];
      end else begin
         wr_valid = 1'b0;
      end
      if (chg) wr_data = 8'h55;
      c = 0; ps = 1'b0; pd = 1'b0;
      n_edges = 0; first_edge = -1; ready_cyc = -1; got_word = 0;
      edge_bad = 0; gap_bad = 0; busy_bad = 0; unstable = 0; c1_ok = 0;
      while (c < 400) begin
         @(negedge clk);
         c++;
         if (c == 1)
            c1_ok = (sck === 1'b0 && sdi === 1'b1 && busy === 1'b1
                     && wr_ready === 1'b0) ? 1 : 0;
         if (wr_ready === 1'b1) begin
            ready_cyc = c;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
         if (sck === 1'b1 && ps === 1'b0) begin
            got_word = (got_word << 1) | int'(sdi);
            if (n_edges == 0) first_edge = c;
            if (c != 1 + CD * (2 * n_edges + 1)) edge_bad++;
            n_edges++;
         end
         if (sck === 1'b1 && ps === 1'b1 && sdi !== pd) unstable++;
         if (c > NB * 2 * CD && (sck !== 1'b0 || sdi !== 1'b0)) gap_bad++;
         ps = sck;
         pd = sdi;
      end
   endtask

   task automatic judge(input string nm, input int a, input int d);
      checks++;
      if (pre_ready !== 1 || c1_ok !== 1) begin
         failures++;
         $display("FAIL %s start: ready_before=%0d cycle1_ok=%0d required 1/1",
                  nm, pre_ready, c1_ok);
      end
      checks++;
      if (n_edges !== NB || got_word !== model_word(a, d)) begin
         failures++;
         $display("FAIL %s bits: got %0d edges word=%h required %0d edges word=%h",
                  nm, n_edges, got_word, NB, model_word(a, d));
      end
      checks++;
      if (first_edge !== 1 + CD || edge_bad !== 0) begin
         failures++;
         $display("FAIL %s edge timing: first=%0d misplaced=%0d required first=%0d misplaced=0",
                  nm, first_edge, edge_bad, 1 + CD);
      end
      checks++;
      if (ready_cyc !== model_ready_cyc()) begin
         failures++;
         $display("FAIL %s ready cycle: got %0d required %0d",
                  nm, ready_cyc, model_ready_cyc());
      end
      checks++;
      if (gap_bad !== 0 || busy_bad !== 0 || unstable !== 0) begin
         failures++;
         $display("FAIL %s framing: gap_bad=%0d busy_bad=%0d sdi_unstable=%0d required 0/0/0",
                  nm, gap_bad, busy_bad, unstable);
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (sck !== 1'b0 || sdi !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1)
            bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL reset_idle: %0d bad idle cycles, required 0", bad);
      end
   endtask

   task automatic test_basic();
      run_frame(5, 8'hA3, 1'b0, 0, 0, 1'b0);
      judge("basic_5_A3", 5, 8'hA3);
   endtask

   task automatic test_back_to_back();
      int first_ready;
      run_frame(0, 8'h00, 1'b1, 7, 8'hFF, 1'b0);
      judge("b2b_first", 0, 8'h00);
      first_ready = ready_cyc;
      run_frame(7, 8'hFF, 1'b0, 0, 0, 1'b0);
      judge("b2b_second", 7, 8'hFF);
      checks++;
      if (first_ready !== model_ready_cyc()) begin
         failures++;
         $display("FAIL b2b_accept: first idle cycle %0d required %0d",
                  first_ready, model_ready_cyc());
      end
   endtask

   task automatic test_data_change();
      run_frame(1, 8'h3C, 1'b0, 0, 0, 1'b1);
      judge("late_change", 1, 8'h3C);
   endtask

   task automatic test_mid_reset();
      int c;
      wr_valid = 1'b1;
      wr_addr = 3'd6;
      wr_data = 8'hF0;
      @(posedge clk);
      #1 wr_valid = 1'b0;
      c = 0;
      while (c < 20) begin
         @(negedge clk);
         c++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (sck !== 1'b0 || sdi !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_async: sck=%b sdi=%b busy=%b required 0/0/0",
                  sck, sdi, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_ready: wr_ready=%b required 1", wr_ready);
      end
      run_frame(2, 8'h81, 1'b0, 0, 0, 1'b0);
      judge("after_reset_2_81", 2, 8'h81);
   endtask

   task automatic test_parity_vectors();
      run_frame(0, 8'h07, 1'b0, 0, 0, 1'b0);
      judge("par_0_07", 0, 8'h07);
      checks++;
      if (NB == 13 && (got_word & 1) !== 1) begin
         failures++;
         $display("FAIL par_bit_0_07: got %0d required 1", got_word & 1);
      end
   endtask

   task automatic test_random();
      int a, d;
      for (int i = 0; i < 6; i++) begin
         a = int'($urandom_range(0, 7));
         d = int'($urandom_range(0, 255));
         repeat (int'($urandom_range(0, 3))) @(negedge clk);
         run_frame(a, d, 1'b0, 0, 0, 1'b0);
         judge("random", a, d);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_data_change();
      test_mid_reset();
      test_parity_vectors();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
